// File: rtl/bus_defines.sv
// Shared constants for the bus master arbiter: FSM encodings, default sizes
// and the fixed master slot assignments.
package bus_defines;

  localparam int DEF_MASTER_NUM = 4;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;

  localparam int DEBUG_UART_IDX = 0;
  localparam int JTAG_IDX       = 1;
  localparam int SPARE_IDX      = 2;
  localparam int CPU_IDX        = 3;

  localparam logic [1:0] ARB_S_IDLE = 2'd0;
  localparam logic [1:0] ARB_S_BUSY = 2'd1;
  localparam logic [1:0] ARB_S_TURN = 2'd2;

  // Next index after i, wrapping at n.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first set request at or after start, wrapping.
// With start tied to 0 this is plain fixed priority (index 0 highest).
module arb_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (int'(start) + i) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = IW'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Single-bus arbiter with burst locking, one turnaround cycle and CPU hold.
// Define BUS_ARB_RR_EN to replace fixed priority with round-robin selection.
module bus_master_arbiter #(
  parameter int MASTER_NUM = bus_defines::DEF_MASTER_NUM,
  parameter int ADDR_W     = bus_defines::DEF_ADDR_W,
  parameter int DATA_W     = bus_defines::DEF_DATA_W,
  parameter int CPU_IDX    = bus_defines::CPU_IDX
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MASTER_NUM-1:0]          m_req_i,
  input  logic [MASTER_NUM-1:0]          m_we_i,
  input  logic [MASTER_NUM*ADDR_W-1:0]   m_addr_i,
  input  logic [MASTER_NUM*DATA_W-1:0]   m_wdata_i,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic [MASTER_NUM-1:0]          m_gnt_o,
  output logic                           s_we_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  input  logic [DATA_W-1:0]              s_rdata_i,
  output logic [$clog2(MASTER_NUM)-1:0]  owner_o,
  output logic                           hold_o
);
  import bus_defines::*;

  localparam int IW = $clog2(MASTER_NUM);

  logic [1:0]            state;
  logic [IW-1:0]         start;
  logic [IW-1:0]         pick_idx;
  logic [MASTER_NUM-1:0] pick_oh;
  logic                  pick_any;
  logic                  busy;

  logic [MASTER_NUM-1:0][ADDR_W-1:0] addr_v;
  logic [MASTER_NUM-1:0][DATA_W-1:0] wdata_v;

`ifdef BUS_ARB_RR_EN
  logic [IW-1:0] last_owner;

  // Pointer starts at the last slot so the first search after reset begins at 0.
  always_ff @(posedge clk) begin
    if (rst)
      last_owner <= IW'(MASTER_NUM - 1);
    else if (state == ARB_S_IDLE && pick_any)
      last_owner <= pick_idx;
  end

  always_comb start = IW'(wrap_inc(int'(last_owner), MASTER_NUM));
`else
  assign start = '0;
`endif

  arb_pick #(.N(MASTER_NUM), .IW(IW)) u_pick (
    .req    (m_req_i),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_S_IDLE;
      m_gnt_o <= '0;
      owner_o <= '0;
    end else begin
      case (state)
        ARB_S_IDLE: begin
          if (pick_any) begin
            m_gnt_o <= pick_oh;
            owner_o <= pick_idx;
            state   <= ARB_S_BUSY;
          end
        end
        ARB_S_BUSY: begin
          // Locked to the owner; other requests are ignored until it lets go.
          if (!m_req_i[owner_o]) begin
            m_gnt_o <= '0;
            owner_o <= '0;
            state   <= ARB_S_TURN;
          end
        end
        ARB_S_TURN: state <= ARB_S_IDLE;
        default: begin
          state   <= ARB_S_IDLE;
          m_gnt_o <= '0;
          owner_o <= '0;
        end
      endcase
    end
  end

  assign addr_v  = m_addr_i;
  assign wdata_v = m_wdata_i;
  assign busy    = (state == ARB_S_BUSY);

  assign s_addr_o  = busy ? addr_v[owner_o]  : '0;
  assign s_wdata_o = busy ? wdata_v[owner_o] : '0;
  assign s_we_o    = busy & m_we_i[owner_o];
  assign m_rdata_o = s_rdata_i;

  assign hold_o = m_req_i[CPU_IDX] & ~m_gnt_o[CPU_IDX];

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Vector-table bench for bus_master_arbiter with a small expected-result queue.
module tb_bus_master_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NONE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   m_req, m_we, m_gnt;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, s_rdata, s_wdata;
  logic [AW-1:0]   s_addr;
  logic            s_we, hold;
  logic [1:0]      owner;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] addr_tab [NM];
  logic [DW-1:0] wdata_tab [NM];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] gnt;
    logic [1:0] owner;
    int         bus;       // master expected on the bus, NONE when idle
    logic       hold_pre;  // hold before the edge
    logic       hold;      // hold after the edge
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  bus_master_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_req_i   (m_req),
    .m_we_i    (m_we),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_rdata_o (m_rdata),
    .m_gnt_o   (m_gnt),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_rdata_i (s_rdata),
    .owner_o   (owner),
    .hold_o    (hold)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] w,
                              input logic [3:0] g, input logic [1:0] o, input int b,
                              input logic hp, input logic h);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.gnt = g; v.owner = o;
    v.bus = b; v.hold_pre = hp; v.hold = h;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    exp_q.push_back(v);
    @(negedge clk);
    rst = v.rst; m_req = v.req; m_we = v.we;
    s_rdata = $urandom;
    #1;
    chk("hold_pre", idx, 32'(hold), 32'(v.hold_pre));
    chk("rdata", idx, m_rdata, s_rdata);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    e_we    = (e.bus == NONE) ? 1'b0  : e.we[e.bus];
    e_addr  = (e.bus == NONE) ? '0    : addr_tab[e.bus];
    e_wdata = (e.bus == NONE) ? '0    : wdata_tab[e.bus];
    chk("gnt",   idx, 32'(m_gnt), 32'(e.gnt));
    chk("owner", idx, 32'(owner), 32'(e.owner));
    chk("s_we",  idx, 32'(s_we),  32'(e_we));
    chk("s_addr", idx, s_addr, e_addr);
    chk("s_wdata", idx, s_wdata, e_wdata);
    chk("hold",  idx, 32'(hold), 32'(e.hold));
  endtask

  initial begin
    int n;
    int w;
    logic [3:0] oh;
    logic [3:0] rel;
    logic       nc;
    rst = 1'b1; m_req = '0; m_we = '0; s_rdata = '0;
    for (int k = 0; k < NM; k++) begin
      addr_tab[k]  = 32'h3000_0008 + 32'(k) * 32'h100;
      wdata_tab[k] = 32'h1B8 + 32'(k);
      m_addr[k*AW +: AW]  = addr_tab[k];
      m_wdata[k*DW +: DW] = wdata_tab[k];
    end

    //           rst  req      we       gnt      own  bus   hp h
    // CPU alone: one cycle of hold, then granted
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 3,    1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 3,    0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    // 0 and CPU together: 0 wins, writes, master 1 write ignored, CPU after turn
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b0001, 0, 0,    1, 1));
    tbl.push_back(mk(0, 4'b1001, 4'b0001, 4'b0001, 0, 0,    1, 1));
    tbl.push_back(mk(0, 4'b1001, 4'b0010, 4'b0001, 0, 0,    1, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 0, NONE, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 0, NONE, 1, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 3, 3,    1, 0));
    // CPU owns; master 0 cannot pre-empt; granted 2 cycles after release
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b1000, 3, 3,    0, 0));
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 4'b1000, 3, 3,    0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0,    0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    // reset while master 2 writes, then re-grant one cycle after reset
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 2, 2,    0, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 2, 2,    0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    // simultaneous 1,2,3: policy decides
`ifdef BUS_ARB_RR_EN
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 4'b1000, 3, 3,    1, 0));
`else
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 4'b0010, 1, 1,    1, 1));
`endif
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    // master 2 asks while 0 is locked, drops before grant: lost
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0,    0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0001, 0, 0,    0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0));

    n = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], n);
      n++;
    end

    // All four keep requesting; each owner releases after 3 granted cycles.
    apply(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, NONE, 0, 0), n++);
    for (int k = 0; k < 5; k++) begin
`ifdef BUS_ARB_RR_EN
      w = k % NM;
`else
      w = 0;
`endif
      oh = 4'b0001 << w;
      rel = 4'b1111 & ~oh;
      nc = (w != 3);
      apply(mk(0, 4'b1111, 4'b0000, oh, 2'(w), w, 1, nc), n++);
      apply(mk(0, 4'b1111, 4'b0000, oh, 2'(w), w, nc, nc), n++);
      apply(mk(0, 4'b1111, 4'b0000, oh, 2'(w), w, nc, nc), n++);
      apply(mk(0, rel, 4'b0000, 4'b0000, 0, NONE, nc, nc), n++);
      apply(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, NONE, 1, 1), n++);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
